pc_watch_monitor: RTL and testbench

//  Synthesizable run-verdict monitor for the rv32i core. It samples the fetch/decode PC
//  and an illegal-opcode flag each cycle and compares the PC against a programmable table
//  of PASS/FAIL vectors. It also enforces a cycle budget and latches a sticky verdict
//  (pass/fail/timeout) with diagnostics. It sits beside core, fed from FD-stage signals,
//  so directed programs self-check in simulation or on FPGA.

---
 rtl/pc_watch_monitor_pkg.sv | 16 +
 rtl/pc_watch_monitor_cam.sv | 74 +++++++
 rtl/pc_watch_monitor.sv | 173 +++++++++++++++++
 tb/tb_pc_watch_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_watch_monitor_pkg.sv
// Shared definitions for the PC watch monitor: FSM state encodings and the
// watch-entry kind constants used by the table and the top-level verdict logic.
package pc_watch_monitor_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRun     = 3'd1,
    StPass    = 3'd2,
    StFail    = 3'd3,
    StTimeout = 3'd4
  } state_e;

  localparam logic WATCH_FAIL = 1'b0;
  localparam logic WATCH_PASS = 1'b1;

endpackage

// File: rtl/pc_watch_monitor_cam.sv
// Watch table for the PC watch monitor: NUM_WATCH programmable entries
// (valid, kind, PC[31:2]) compared in parallel against the current PC word address.
// Ports:
//   clk, resetb      clock / async active-low reset (clears all valid bits)
//   i_we, i_idx      write strobe and entry index (out-of-range indices are dropped)
//   i_valid, i_kind  entry enable and kind (WATCH_FAIL / WATCH_PASS)
//   i_addr           entry word address PC[31:2]
//   i_pc_addr        current PC[31:2] to compare
//   o_fail_any/idx   some FAIL entry hits; lowest hitting FAIL index
//   o_pass_any/idx   some PASS entry hits; lowest hitting PASS index
module pc_watch_monitor_cam
  import pc_watch_monitor_pkg::*;
#(
  parameter int unsigned NUM_WATCH = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_valid,
  input  logic             i_kind,
  input  logic [29:0]      i_addr,
  input  logic [29:0]      i_pc_addr,
  output logic             o_fail_any,
  output logic [IDX_W-1:0] o_fail_idx,
  output logic             o_pass_any,
  output logic [IDX_W-1:0] o_pass_idx
);

  logic [NUM_WATCH-1:0] r_valid;
  logic [NUM_WATCH-1:0] r_kind;
  logic [29:0]          r_addr [NUM_WATCH];
  logic [NUM_WATCH-1:0] w_hit;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_valid <= '0;
      r_kind  <= '0;
      for (int i = 0; i < int'(NUM_WATCH); i++) begin
        r_addr[i] <= '0;
      end
    end else if (i_we && (32'(i_idx) < NUM_WATCH)) begin
      r_valid[i_idx] <= i_valid;
      r_kind[i_idx]  <= i_kind;
      r_addr[i_idx]  <= i_addr;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_WATCH); i++) begin
      w_hit[i] = r_valid[i] && (r_addr[i] == i_pc_addr);
    end
  end

  // Scan from the top so the lowest hitting index is the last one written.
  always_comb begin
    o_fail_any = 1'b0;
    o_fail_idx = '0;
    o_pass_any = 1'b0;
    o_pass_idx = '0;
    for (int i = int'(NUM_WATCH) - 1; i >= 0; i--) begin
      if (w_hit[i] && (r_kind[i] == WATCH_FAIL)) begin
        o_fail_any = 1'b1;
        o_fail_idx = IDX_W'(i);
      end
      if (w_hit[i] && (r_kind[i] == WATCH_PASS)) begin
        o_pass_any = 1'b1;
        o_pass_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pc_watch_monitor.sv
// Run-verdict monitor for the rv32i core. Samples the FD-stage PC and illegal flag,
// matches the PC against a programmable PASS/FAIL watch table, enforces a cycle
// budget, and latches a sticky verdict with diagnostics.
// Ports:
//   clk, resetb        clock / async active-low reset
//   cfg_*              watch table write port (honoured in IDLE only)
//   budget             cycle budget sampled at start (0 = unlimited)
//   start, clear       begin a run / return to IDLE (clear wins)
//   pc_valid, pc,      FD-stage sample qualifier, PC and illegal-opcode flag
//   illegal
//   busy/done/pass/    state decode outputs
//   fail/timeout
//   fail_illegal,      verdict diagnostics, loaded on the verdict edge
//   hit_idx, hit_pc
//   cycles             RUN cycles elapsed, frozen after the verdict
module pc_watch_monitor
  import pc_watch_monitor_pkg::*;
#(
  parameter int unsigned NUM_WATCH = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned ARM_DELAY = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_valid,
  input  logic             cfg_kind,
  input  logic [29:0]      cfg_addr,
  input  logic [CNT_W-1:0] budget,
  input  logic             start,
  input  logic             clear,
  input  logic             pc_valid,
  input  logic [31:0]      pc,
  input  logic             illegal,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             fail_illegal,
  output logic [IDX_W-1:0] hit_idx,
  output logic [31:0]      hit_pc,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned     ARM_W   = (ARM_DELAY < 1) ? 1 : $clog2(ARM_DELAY + 1);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(ARM_DELAY);

  state_e           r_state;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_budget;
  logic [ARM_W-1:0] r_arm;
  logic             r_fail_illegal;
  logic [IDX_W-1:0] r_hit_idx;
  logic [31:0]      r_hit_pc;

  logic             w_cam_we;
  logic             w_fail_any;
  logic             w_pass_any;
  logic [IDX_W-1:0] w_fail_idx;
  logic [IDX_W-1:0] w_pass_idx;
  logic             w_armed;
  logic             w_active;
  logic             w_fail_hit;
  logic             w_illegal;
  logic             w_pass_hit;
  logic             w_timeout;
  logic             w_unused_pc;

  // Table is frozen outside IDLE so a run always sees a stable configuration.
  assign w_cam_we = cfg_we && (r_state == StIdle);

  pc_watch_monitor_cam #(
    .NUM_WATCH(NUM_WATCH),
    .IDX_W    (IDX_W)
  ) u_cam (
    .clk       (clk),
    .resetb    (resetb),
    .i_we      (w_cam_we),
    .i_idx     (cfg_idx),
    .i_valid   (cfg_valid),
    .i_kind    (cfg_kind),
    .i_addr    (cfg_addr),
    .i_pc_addr (pc[31:2]),
    .o_fail_any(w_fail_any),
    .o_fail_idx(w_fail_idx),
    .o_pass_any(w_pass_any),
    .o_pass_idx(w_pass_idx)
  );

  assign w_unused_pc = ^pc[1:0];

  assign w_armed    = (r_arm == ARM_MAX);
  assign w_active   = pc_valid && w_armed;
  assign w_fail_hit = w_active && w_fail_any;
  assign w_illegal  = w_active && illegal;
  assign w_pass_hit = w_active && w_pass_any;
  assign w_timeout  = (r_budget != '0) && (r_cycles == (r_budget - CNT_W'(1)));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state        <= StIdle;
      r_cycles       <= '0;
      r_budget       <= '0;
      r_arm          <= '0;
      r_fail_illegal <= 1'b0;
      r_hit_idx      <= '0;
      r_hit_pc       <= '0;
    end else if (clear) begin
      r_state        <= StIdle;
      r_cycles       <= '0;
      r_arm          <= '0;
      r_fail_illegal <= 1'b0;
      r_hit_idx      <= '0;
      r_hit_pc       <= '0;
    end else begin
      case (r_state)
        StRun: begin
          if (!w_armed) begin
            r_arm <= r_arm + ARM_W'(1);
          end
          if (w_fail_hit) begin
            r_state        <= StFail;
            r_fail_illegal <= 1'b0;
            r_hit_idx      <= w_fail_idx;
            r_hit_pc       <= pc;
          end else if (w_illegal) begin
            r_state        <= StFail;
            r_fail_illegal <= 1'b1;
            r_hit_idx      <= '0;
            r_hit_pc       <= pc;
          end else if (w_pass_hit) begin
            r_state   <= StPass;
            r_hit_idx <= w_pass_idx;
            r_hit_pc  <= pc;
          end else if (w_timeout) begin
            r_state   <= StTimeout;
            r_hit_idx <= '0;
            r_hit_pc  <= '0;
          end else if (r_cycles != '1) begin
            // The verdict cycle is not counted, so cycles freezes at its last RUN value.
            r_cycles <= r_cycles + CNT_W'(1);
          end
        end
        default: begin
          // IDLE and all terminal states accept start.
          if (start) begin
            r_state        <= StRun;
            r_cycles       <= '0;
            r_budget       <= budget;
            r_arm          <= '0;
            r_fail_illegal <= 1'b0;
            r_hit_idx      <= '0;
            r_hit_pc       <= '0;
          end
        end
      endcase
    end
  end

  assign busy         = (r_state == StRun);
  assign pass         = (r_state == StPass);
  assign fail         = (r_state == StFail);
  assign timeout      = (r_state == StTimeout);
  assign done         = pass || fail || timeout;
  assign fail_illegal = r_fail_illegal;
  assign hit_idx      = r_hit_idx;
  assign hit_pc       = r_hit_pc;
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_pc_watch_monitor.sv
// Directed self-checking bench for pc_watch_monitor with default parameters.
module tb_pc_watch_monitor;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 24;

  logic             clk = 1'b0;
  logic             resetb = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_kind = 1'b0;
  logic [29:0]      cfg_addr = '0;
  logic [CNT_W-1:0] budget = '0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             pc_valid = 1'b0;
  logic [31:0]      pc = '0;
  logic             illegal = 1'b0;
  logic             busy, done, pass, fail, timeout, fail_illegal;
  logic [IDX_W-1:0] hit_idx;
  logic [31:0]      hit_pc;
  logic [CNT_W-1:0] cycles;

  int checks = 0;
  int failures = 0;

  pc_watch_monitor dut (
    .clk         (clk),
    .resetb      (resetb),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_valid   (cfg_valid),
    .cfg_kind    (cfg_kind),
    .cfg_addr    (cfg_addr),
    .budget      (budget),
    .start       (start),
    .clear       (clear),
    .pc_valid    (pc_valid),
    .pc          (pc),
    .illegal     (illegal),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .fail_illegal(fail_illegal),
    .hit_idx     (hit_idx),
    .hit_pc      (hit_pc),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // busy, pass, fail, timeout, done in one go.
  task automatic chk_state(input string tag, input logic b, input logic p, input logic f,
                           input logic t);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".pass"}, 32'(pass), 32'(p));
    chk({tag, ".fail"}, 32'(fail), 32'(f));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    chk({tag, ".done"}, 32'(done), 32'(p | f | t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic valid, input logic kind,
                           input logic [31:0] addr);
    cfg_we    = 1'b1;
    cfg_idx   = IDX_W'(idx);
    cfg_valid = valid;
    cfg_kind  = kind;
    cfg_addr  = addr[31:2];
    pc_valid  = 1'b0;
    illegal   = 1'b0;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input int unsigned b);
    budget   = CNT_W'(b);
    start    = 1'b1;
    pc_valid = 1'b0;
    illegal  = 1'b0;
    step();
    start  = 1'b0;
    budget = '0;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    pc_valid = 1'b0;
    illegal  = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic feed(input logic [31:0] p, input logic ill);
    pc_valid = 1'b1;
    pc       = p;
    illegal  = ill;
    step();
    pc_valid = 1'b0;
    illegal  = 1'b0;
  endtask

  logic [31:0] loop_pcs [5];

  initial begin
    loop_pcs[0] = 32'h0C; loop_pcs[1] = 32'h14; loop_pcs[2] = 32'h18;
    loop_pcs[3] = 32'h1C; loop_pcs[4] = 32'h20;

    // Reset state.
    #12;
    chk_state("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.cycles", 32'(cycles), 32'h0);
    chk("rst.hit_pc", hit_pc, 32'h0);
    resetb = 1'b1;
    step();

    // 1: PASS vector reached.
    cfg_write(0, 1'b1, 1'b0, 32'h10);
    cfg_write(1, 1'b1, 1'b1, 32'h40);
    start_run(100);
    chk_state("t1.start", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1.start.cycles", 32'(cycles), 32'h0);
    feed(32'h00, 1'b0);
    feed(32'h0C, 1'b0);
    for (int a = 32'h14; a <= 32'h3C; a += 4) feed(32'(a), 1'b0);
    chk_state("t1.pre", 1'b1, 1'b0, 1'b0, 1'b0);
    feed(32'h40, 1'b0);
    chk_state("t1.pass", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1.hit_idx", 32'(hit_idx), 32'h1);
    chk("t1.hit_pc", hit_pc, 32'h40);
    chk("t1.cycles", 32'(cycles), 32'd13);

    // 2: FAIL vector from terminal restart, then clear.
    start_run(100);
    chk("t2.start.hit_pc", hit_pc, 32'h0);
    chk("t2.start.busy", 32'(busy), 32'h1);
    feed(32'h00, 1'b0);
    feed(32'h0C, 1'b0);
    feed(32'h10, 1'b0);
    chk_state("t2.fail", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2.hit_idx", 32'(hit_idx), 32'h0);
    chk("t2.hit_pc", hit_pc, 32'h10);
    chk("t2.fail_illegal", 32'(fail_illegal), 32'h0);
    do_clear();
    chk_state("t2.clear", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2.clear.hit_pc", hit_pc, 32'h0);

    // 3: illegal ignored during arm window, then fails.
    start_run(100);
    feed(32'hFFFF_FFFC, 1'b1);
    chk_state("t3.arm0", 1'b1, 1'b0, 1'b0, 1'b0);
    feed(32'hFFFF_FFFC, 1'b1);
    chk_state("t3.arm1", 1'b1, 1'b0, 1'b0, 1'b0);
    feed(32'h08, 1'b1);
    chk_state("t3.fail", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3.fail_illegal", 32'(fail_illegal), 32'h1);
    chk("t3.hit_pc", hit_pc, 32'h08);
    chk("t3.hit_idx", 32'(hit_idx), 32'h0);

    // 4: budget expiry.
    start_run(12);
    chk("t4.start.fail_illegal", 32'(fail_illegal), 32'h0);
    for (int k = 0; k < 11; k++) feed(loop_pcs[k % 5], 1'b0);
    chk_state("t4.pre", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4.pre.cycles", 32'(cycles), 32'd11);
    feed(loop_pcs[11 % 5], 1'b0);
    chk_state("t4.timeout", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4.cycles", 32'(cycles), 32'd11);
    chk("t4.hit_pc", hit_pc, 32'h0);
    chk("t4.hit_idx", 32'(hit_idx), 32'h0);
    step();
    chk("t4.frozen", 32'(cycles), 32'd11);

    // 5: FAIL beats PASS in the same cycle; cfg_we in RUN is dropped; pc[1:0] ignored.
    do_clear();
    cfg_write(2, 1'b1, 1'b0, 32'h10);
    cfg_write(0, 1'b1, 1'b1, 32'h10);
    start_run(100);
    feed(32'h00, 1'b0);
    feed(32'h04, 1'b0);
    feed(32'h10, 1'b0);
    chk_state("t5.fail", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5.hit_idx", 32'(hit_idx), 32'h2);
    start_run(100);
    cfg_write(3, 1'b1, 1'b1, 32'h08);
    feed(32'h00, 1'b0);
    feed(32'h08, 1'b0);
    chk_state("t5.nowrite", 1'b1, 1'b0, 1'b0, 1'b0);
    feed(32'h43, 1'b0);
    chk_state("t5.pass", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5.pass.hit_idx", 32'(hit_idx), 32'h1);
    chk("t5.pass.hit_pc", hit_pc, 32'h43);

    // 6: async reset mid-run wipes state and table.
    start_run(100);
    feed(32'h00, 1'b0);
    feed(32'h04, 1'b0);
    resetb = 1'b0;
    #1;
    chk_state("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.rst.cycles", 32'(cycles), 32'h0);
    #2;
    resetb = 1'b1;
    step();
    start_run(5);
    feed(32'h10, 1'b0);
    feed(32'h40, 1'b0);
    feed(32'h10, 1'b0);
    feed(32'h40, 1'b0);
    chk_state("t6.pre", 1'b1, 1'b0, 1'b0, 1'b0);
    feed(32'h10, 1'b0);
    chk_state("t6.timeout", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6.cycles", 32'(cycles), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
